// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Used by both the receiver and the transmitter.
package uart_pkg;

  // Receiver / transmitter FSM states. Encodings are fixed so that
  // state values look the same on both sides of the link in waveforms.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  // Default bit period minus one, in clock cycles.
  localparam int unsigned BAUD_CNT_MAX_DEFAULT = 10416;

  // Number of data bits in an 8N1 frame.
  localparam int unsigned DATA_BITS = 8;

  // Width needed to hold a baud counter that runs 0..max_cnt.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    int unsigned w;
    w = 1;
    while ((2 ** w) <= max_cnt) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Serial input conditioning: two-flop synchronizer for the asynchronous
// line, one extra delay stage, and a falling-edge detector on the result.
// All flops reset to 1 so that an idle (high) line after reset is not
// mistaken for a start edge.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic fall
);

  logic sync1;
  logic din_d;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      din_s <= 1'b1;
      din_d <= 1'b1;
    end else begin
      sync1 <= din;
      din_s <= sync1;
      din_d <= din_s;
    end
  end

  // A start edge is a high-to-low transition of the synchronized line.
  assign fall = din_d & ~din_s;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first.
//
// A falling edge of the synchronized line starts a frame. The start bit is
// re-checked at mid-bit to reject glitches; data bits and the stop bit are
// then sampled one full bit period apart, which keeps every sample near the
// centre of its bit.
//
// Build option: define UART_RECV_FRAME_CHECK_EN to report a stop bit of 0
// as a one-cycle frame_err pulse (no valid, data kept). Without it,
// frame_err is tied low and a bad stop bit is accepted as a good frame.
//
// Handshake: valid is a single-cycle strobe with no ready; data is loaded
// on the same edge valid rises and then holds until the next valid strobe.
// valid and frame_err are never high together.
module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_MAX = BAUD_CNT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = cnt_width(BAUD_CNT_MAX);

  // Counter values where the FSM acts: mid start bit, end of each bit.
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BAUD_CNT_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BAUD_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

  logic din_s;
  logic fall;

`ifdef UART_RECV_FRAME_CHECK_EN
  logic frame_err_q;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .fall  (fall)
  );

  // Receive FSM with registered strobes; counters and shifter live here too
  // so every state change is visible in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
`ifdef UART_RECV_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      // Strobes last one cycle unless re-asserted below.
      valid <= 1'b0;
`ifdef UART_RECV_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif

      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          // Only an edge starts a frame; a line stuck low does not retrigger.
          if (fall) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (baud_cnt == CNT_MID) begin
            baud_cnt <= '0;
            // Line back high at mid start bit means it was a glitch.
            if (din_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (baud_cnt == CNT_END) begin
            baud_cnt           <= '0;
            shift_reg[bit_cnt] <= din_s;
            bit_cnt            <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (baud_cnt == CNT_END) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (din_s) begin
              data  <= shift_reg;
              valid <= 1'b1;
            end else begin
`ifdef UART_RECV_FRAME_CHECK_EN
              // Bad stop bit: report it and keep the previous byte.
              frame_err_q <= 1'b1;
`else
              // Stop bit is not checked; accept the byte as received.
              data  <= shift_reg;
              valid <= 1'b1;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Busy covers the whole frame, from start edge until the stop sample.
  assign busy = (state != IDLE);

`ifdef UART_RECV_FRAME_CHECK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
